ov7670_sccb_sender: RTL and testbench
=====================================

# ov7670_sccb_sender

- Consumes the 16-bit `{register, value}` command stream from the OV7670 register table and serialises each entry as an SCCB 3-phase write (device ID, register address, data) on SIOC/SIOD.
- Pulses `advance` to fetch the next entry.
- Stops when the table reports `finished`.
- Sits between the register table and the camera's SCCB pins; it is the configuration path that runs before the capture pipeline.

## Interface
- `CLK_DIV`, default 250: clk cycles per SCL quarter-period (100 MHz → 100 kHz SCL); must be ≥ 2.
- `DEVICE_ID`, default 8'h42: SCCB write address.
- `POST_RESET_DELAY`, default 1_000_000: extra idle clk cycles after a command whose register is 8'h12 with value bit 7 set.
- `SETTLE`, default 4: clk cycles between `advance` (or reset release) and sampling `command`.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `command` in 16: [15:8] register address, [7:0] value.
- `finished` in 1: high when `command` == 16'hFFFF (end of table).
- `advance` out 1: one-cycle pulse when a command has been fully sent.
- `config_done` out 1: sticky; high once `finished` is sampled.
- `sioc` out 1: SCCB clock.
- `siod_out` out 1: SCCB data drive level.
- `siod_oe` out 1: SIOD output enable; 0 = released (pulled up).

## Operation
- **Reset values:** `sioc`=1, `siod_out`=1, `siod_oe`=1, `advance`=0, `config_done`=0, state SETTLE, all counters 0.
- **Quarter tick:** a counter runs 0..CLK_DIV-1 while in START/BITS/STOP/GAP. Its wrap produces `qtick`. The counter clears on every state entry.
- **SETTLE:** count SETTLE cycles, then sample `finished` and `command`.
  - If `finished`=1: go to DONE.
  - Otherwise latch `shift = {DEVICE_ID,1'b1,command[15:8],1'b1,command[7:0],1'b1}` (27 bits) and go to START.
- **START**, 2 quarters:
  - q0: `sioc`=1, `siod_out`=0.
  - q1: `sioc`=0.
- **BITS:** 27 bits MSB first, 4 quarters each.
  - q0: `sioc`=0, present bit.
  - q1: `sioc`=0.
  - q2, q3: `sioc`=1.
  - Bit indices 8, 17, 26 (don't-care) drive `siod_oe`=0; all others drive `siod_oe`=1.
  - The 5-bit bit counter terminates at 26.
- **STOP**, 3 quarters:
  - q0: `sioc`=0, `siod_oe`=1, `siod_out`=0.
  - q1: `sioc`=1.
  - q2: `siod_out`=1.
- **GAP:** 4 quarters with the bus idle (`sioc`=1, `siod_out`=1, `siod_oe`=1).
  - Then go to DELAY if the latched register is 8'h12 and value[7]=1; otherwise pulse `advance` and return to SETTLE.
- **DELAY:** count POST_RESET_DELAY cycles with the bus idle, then pulse `advance` and go to SETTLE.
- **DONE:** terminal. `config_done`=1, bus idle, `advance` stays 0. Only `rst` leaves DONE.
- **Latching:** `command` and `finished` are sampled only at the end of SETTLE. Changes during a frame are ignored.
- **Reset mid-frame:** the aborted command is not counted (no `advance`). The bus returns idle the cycle after `rst`, and the same table entry is resent after settle.

## Timing
- Sampling happens SETTLE cycles after the `advance` pulse. The upstream command is valid ≥ 2 cycles after `advance`, so SETTLE ≥ 3 is mandatory.
- Frame length from leaving SETTLE to the `advance` pulse:
  - (2+108+3+4)·CLK_DIV cycles = 117·CLK_DIV.
  - Add POST_RESET_DELAY when DELAY is taken.
- `advance` is high for exactly 1 cycle and is registered.
- All outputs are registered; no combinational path from inputs to outputs.
- A `rst` held high for one cycle forces the reset values on the next clk edge.

## Structure
- Package `ov7670_pkg`:
  - `sccb_state_t` enum: SETTLE, START, BITS, STOP, GAP, DELAY, DONE.
  - `SCCB_TERMINATOR` = 16'hFFFF.
  - `OV_REG_COM7` = 8'h12.
  - `SCCB_FRAME_BITS` = 27.
  - `SCCB_DONTCARE_IDX` {8, 17, 26}.
- One sub-module, `sccb_tick_gen`: the quarter-tick divider, with a clear input and a `qtick` output. The FSM, shift register and bit/quarter counters stay in the top module.

## Test plan
1. CLK_DIV=2, SETTLE=4. Release reset with command=16'h1711.
   - Decode SIOD on SIOC rising edges → 0x42, Z, 0x17, Z, 0x11, Z.
   - One `advance` pulse occurs exactly 234 cycles after START entry.
2. command=16'h1280, POST_RESET_DELAY=20.
   - `advance` arrives 20 cycles later than in scenario 1.
   - command=16'h1200 → no delay.
3. Four-entry table model (1280, 1200, 3A14, FFFF).
   - Exactly 3 frames are sent.
   - `config_done`=1 after the fourth sample; SIOC/SIOD stay 1 for 10k cycles with no further `advance`.
4. Assert `rst` for 1 cycle at bit index 12 of a frame.
   - Next cycle: `sioc`=1, `siod_out`=1, `siod_oe`=1, no `advance`.
   - After settle, the same command is resent in full.
5. Change `command` to 16'hABCD mid-frame → the frame still carries the originally latched bytes.
6. Hold `finished`=1 from reset.
   - `config_done` rises SETTLE+1 cycles after reset release.
   - No START condition ever appears on the bus.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types, constants and frame helpers for the OV7670 SCCB configuration path.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_START,
    ST_BITS,
    ST_STOP,
    ST_GAP,
    ST_DELAY,
    ST_DONE
  } sccb_state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] value;
  } sccb_cmd_t;

  localparam logic [15:0]  SCCB_TERMINATOR = 16'hFFFF;
  localparam logic [7:0]   OV_REG_COM7     = 8'h12;
  localparam int unsigned  SCCB_FRAME_BITS = 27;
  localparam int unsigned  SCCB_BIT_W      = 5;
  localparam logic [14:0]  SCCB_DONTCARE_IDX = {5'd8, 5'd17, 5'd26};

  // Bus order: ID, don't-care, register, don't-care, value, don't-care (MSB first).
  function automatic logic [SCCB_FRAME_BITS-1:0] sccb_frame(input logic [7:0] id,
                                                            input sccb_cmd_t  cmd);
    return {id, 1'b1, cmd.addr, 1'b1, cmd.value, 1'b1};
  endfunction

  function automatic logic sccb_is_dontcare(input logic [SCCB_BIT_W-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (idx == SCCB_DONTCARE_IDX[i*SCCB_BIT_W +: SCCB_BIT_W]) hit = 1'b1;
    end
    return hit;
  endfunction

  // A COM7 write with bit 7 set soft-resets the sensor, which then needs idle time.
  function automatic logic needs_post_reset_delay(input sccb_cmd_t cmd);
    return (cmd.addr == OV_REG_COM7) && cmd.value[7];
  endfunction

endpackage

// File: rtl/ov7670_sccb_sender_if.sv
// Register-table handshake plus SCCB pin bundle for the configuration sender.
interface ov7670_sccb_sender_if;
  import ov7670_pkg::*;

  sccb_cmd_t command;
  logic      finished;
  logic      advance;
  logic      config_done;
  logic      sioc;
  logic      siod_out;
  logic      siod_oe;

  modport master (
    input  command,
    input  finished,
    output advance,
    output config_done,
    output sioc,
    output siod_out,
    output siod_oe
  );

  modport slave (
    output command,
    output finished,
    input  advance,
    input  config_done,
    input  sioc,
    input  siod_out,
    input  siod_oe
  );
endinterface

// File: rtl/sccb_tick_gen.sv
// Quarter-period divider: qtick_o is high in the last clk of every CLK_DIV-cycle quarter.
module sccb_tick_gen #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clear_i,
  output logic qtick_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qtick_q, qtick_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    qtick_d = (cnt_d == CNT_W'(CLK_DIV - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      qtick_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      qtick_q <= qtick_d;
    end
  end

  assign qtick_o = qtick_q;

endmodule

// File: rtl/ov7670_sccb_sender.sv
// Walks the OV7670 register table and emits each entry as an SCCB 3-phase write.
module ov7670_sccb_sender
  import ov7670_pkg::*;
#(
  parameter int unsigned CLK_DIV          = 250,
  parameter logic [7:0]  DEVICE_ID        = 8'h42,
  parameter int unsigned POST_RESET_DELAY = 1_000_000,
  parameter int unsigned SETTLE           = 4
) (
  input logic                  clk,
  input logic                  rst,
  ov7670_sccb_sender_if.master bus
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE + 2);
  localparam int unsigned DELAY_W  = $clog2(POST_RESET_DELAY + 2);
  localparam logic [SCCB_BIT_W-1:0] BIT_LAST = SCCB_BIT_W'(SCCB_FRAME_BITS - 1);

  sccb_state_t                 state_q, state_d;
  logic [1:0]                  quarter_q, quarter_d;
  logic [SCCB_BIT_W-1:0]       bit_q, bit_d;
  logic [SCCB_FRAME_BITS-1:0]  shift_q, shift_d;
  logic [SETTLE_W-1:0]         settle_q, settle_d;
  logic [DELAY_W-1:0]          delay_q, delay_d;
  logic                        delay_req_q, delay_req_d;
  logic                        advance_q, advance_d;
  logic                        config_done_q, config_done_d;
  logic                        sioc_q, sioc_d;
  logic                        siod_out_q, siod_out_d;
  logic                        siod_oe_q, siod_oe_d;
  logic                        qtick;
  logic                        tick_en;
  logic                        tick_clr;

  assign tick_en  = state_q inside {ST_START, ST_BITS, ST_STOP, ST_GAP};
  assign tick_clr = (state_d != state_q);

  sccb_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en_i    (tick_en),
    .clear_i (tick_clr),
    .qtick_o (qtick)
  );

  always_comb begin
    state_d       = state_q;
    quarter_d     = quarter_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    settle_d      = settle_q;
    delay_d       = delay_q;
    delay_req_d   = delay_req_q;
    advance_d     = 1'b0;
    config_done_d = config_done_q;
    sioc_d        = 1'b1;
    siod_out_d    = 1'b1;
    siod_oe_d     = 1'b1;

    case (state_q)
      ST_SETTLE: begin
        if (settle_q == SETTLE_W'(SETTLE)) begin
          if (bus.finished) begin
            state_d = ST_DONE;
          end else begin
            shift_d     = sccb_frame(DEVICE_ID, bus.command);
            delay_req_d = needs_post_reset_delay(bus.command) && (POST_RESET_DELAY != 0);
            state_d     = ST_START;
          end
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      ST_START: begin
        if (qtick) begin
          if (quarter_q == 2'd1) state_d = ST_BITS;
          else                   quarter_d = quarter_q + 2'd1;
        end
      end
      ST_BITS: begin
        if (qtick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == 2'd3) begin
            if (bit_q == BIT_LAST) begin
              state_d = ST_STOP;
            end else begin
              bit_d   = bit_q + SCCB_BIT_W'(1);
              shift_d = {shift_q[SCCB_FRAME_BITS-2:0], 1'b0};
            end
          end
        end
      end
      ST_STOP: begin
        if (qtick) begin
          if (quarter_q == 2'd2) state_d = ST_GAP;
          else                   quarter_d = quarter_q + 2'd1;
        end
      end
      ST_GAP: begin
        if (qtick) begin
          if (quarter_q == 2'd3) begin
            if (delay_req_q) begin
              state_d = ST_DELAY;
            end else begin
              state_d   = ST_SETTLE;
              advance_d = 1'b1;
            end
          end else begin
            quarter_d = quarter_q + 2'd1;
          end
        end
      end
      ST_DELAY: begin
        if (delay_q == DELAY_W'(POST_RESET_DELAY - 1)) begin
          state_d   = ST_SETTLE;
          advance_d = 1'b1;
        end else begin
          delay_d = delay_q + DELAY_W'(1);
        end
      end
      ST_DONE: ;
      default: state_d = ST_SETTLE;
    endcase

    // Every per-state counter restarts from zero on state entry.
    if (state_d != state_q) begin
      quarter_d = '0;
      bit_d     = '0;
      settle_d  = '0;
      delay_d   = '0;
    end

    config_done_d = config_done_q | (state_d == ST_DONE);

    // Pin levels are decoded from the next state so they register in step with it.
    case (state_d)
      ST_START: begin
        siod_out_d = 1'b0;
        sioc_d     = (quarter_d == 2'd0);
      end
      ST_BITS: begin
        sioc_d     = quarter_d[1];
        siod_out_d = shift_d[SCCB_FRAME_BITS-1];
        siod_oe_d  = !sccb_is_dontcare(bit_d);
      end
      ST_STOP: begin
        sioc_d     = (quarter_d != 2'd0);
        siod_out_d = (quarter_d == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SETTLE;
      quarter_q     <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      settle_q      <= '0;
      delay_q       <= '0;
      delay_req_q   <= 1'b0;
      advance_q     <= 1'b0;
      config_done_q <= 1'b0;
      sioc_q        <= 1'b1;
      siod_out_q    <= 1'b1;
      siod_oe_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      quarter_q     <= quarter_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      settle_q      <= settle_d;
      delay_q       <= delay_d;
      delay_req_q   <= delay_req_d;
      advance_q     <= advance_d;
      config_done_q <= config_done_d;
      sioc_q        <= sioc_d;
      siod_out_q    <= siod_out_d;
      siod_oe_q     <= siod_oe_d;
    end
  end

  assign bus.advance     = advance_q;
  assign bus.config_done = config_done_q;
  assign bus.sioc        = sioc_q;
  assign bus.siod_out    = siod_out_q;
  assign bus.siod_oe     = siod_oe_q;

endmodule

// File: tb/tb_ov7670_sccb_sender.sv
// Table-driven bench: a bus monitor decodes SCCB frames and checks them against queued expectations.
module tb_ov7670_sccb_sender;
  import ov7670_pkg::*;

  localparam int unsigned CD  = 2;
  localparam int unsigned ST  = 4;
  localparam int unsigned PRD = 20;
  localparam logic [7:0]  DEV = 8'h42;

  typedef struct packed {
    logic [23:0] bytes;
    logic [31:0] lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ov7670_sccb_sender_if bus();

  ov7670_sccb_sender #(
    .CLK_DIV          (CD),
    .DEVICE_ID        (DEV),
    .POST_RESET_DELAY (PRD),
    .SETTLE           (ST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];
  logic [15:0] table_q[$];
  logic [26:0] oe_pat;

  int unsigned cyc = 0;
  logic        in_frame = 1'b0;
  int          nb = 0;
  logic [26:0] rx_d, rx_oe;
  int unsigned t0 = 0;
  logic        stop_seen = 1'b0;
  logic        p_sioc = 1'b1, p_out = 1'b1;
  int          frames_done = 0;
  int          starts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: finds START, samples SIOD on SIOC rising edges, scores on advance.
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && p_sioc && p_out && bus.sioc && !bus.siod_out && bus.siod_oe) begin
        in_frame  = 1'b1;
        t0        = cyc;
        nb        = 0;
        stop_seen = 1'b0;
        starts++;
      end else if (in_frame) begin
        if (!p_sioc && bus.sioc && nb < 27) begin
          rx_d[26-nb]  = bus.siod_out;
          rx_oe[26-nb] = bus.siod_oe;
          nb++;
        end else if (nb == 27 && p_sioc && bus.sioc && !p_out && bus.siod_out) begin
          stop_seen = 1'b1;
        end
      end
      if (bus.advance) begin
        check("advance_expected", 32'(in_frame && exp_q.size() != 0), 32'd1);
        if (in_frame && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("frame_bits", 32'(nb), 32'd27);
          check("frame_bytes", 32'({rx_d[26:19], rx_d[17:10], rx_d[8:1]}), 32'(e.bytes));
          check("frame_release_slots", 32'(rx_oe), 32'(oe_pat));
          check("frame_stop", 32'(stop_seen), 32'd1);
          check("frame_latency", cyc - t0, e.lat);
          frames_done++;
        end
        in_frame = 1'b0;
      end
    end
    p_sioc = bus.sioc;
    p_out  = bus.siod_out;
  end

  // Expected frame: ID, register, value bytes; length 117 quarters plus optional COM7 delay.
  task automatic push_exp(input logic [15:0] c);
    exp_t e;
    if (c != SCCB_TERMINATOR) begin
      e.bytes = {DEV, c};
      e.lat   = 32'(117 * CD) + ((c[15:8] == 8'h12 && c[7]) ? 32'(PRD) : 32'd0);
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [15:0] next_entry();
    if (table_q.size() == 0) return SCCB_TERMINATOR;
    return table_q.pop_front();
  endfunction

  task automatic drive_cmd(input logic [15:0] c);
    bus.command  = sccb_cmd_t'(c);
    bus.finished = (c == SCCB_TERMINATOR);
  endtask

  task automatic do_reset(input logic [15:0] c);
    @(posedge clk); #1;
    rst = 1'b1;
    drive_cmd(c);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_sioc", 32'(bus.sioc), 32'd1);
    check("rst_siod_out", 32'(bus.siod_out), 32'd1);
    check("rst_siod_oe", 32'(bus.siod_oe), 32'd1);
    check("rst_advance", 32'(bus.advance), 32'd0);
    check("rst_config_done", 32'(bus.config_done), 32'd0);
  endtask

  task automatic wait_advance(output logic ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 3000) begin
      @(posedge clk); #1;
      ok = bus.advance;
      n++;
    end
    check("advance_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_bits(input int k, output logic ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 1000) begin
      @(posedge clk); #1;
      ok = in_frame && (nb >= k);
      n++;
    end
    check("bit_wait_timeout", 32'(ok), 32'd1);
  endtask

  task automatic run_table(input int rst_bit, input int chg_bit, input int idle_cyc);
    logic [15:0] c;
    logic        ok;
    logic        idle_ok;
    int          sent;
    int          n;
    exp_q.delete();
    frames_done = 0;
    sent = 0;
    c = next_entry();
    do_reset(c);
    push_exp(c);
    if (c != SCCB_TERMINATOR) sent++;
    if (rst_bit >= 0) begin
      wait_bits(rst_bit + 1, ok);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_sioc", 32'(bus.sioc), 32'd1);
      check("midrst_siod_out", 32'(bus.siod_out), 32'd1);
      check("midrst_siod_oe", 32'(bus.siod_oe), 32'd1);
      check("midrst_advance", 32'(bus.advance), 32'd0);
    end
    if (chg_bit >= 0) begin
      wait_bits(chg_bit, ok);
      drive_cmd(16'hABCD);
    end
    while (c != SCCB_TERMINATOR) begin
      wait_advance(ok);
      if (!ok) break;
      @(posedge clk);
      @(posedge clk); #1;
      c = next_entry();
      drive_cmd(c);
      push_exp(c);
      if (c != SCCB_TERMINATOR) sent++;
    end
    n = 0;
    while (!bus.config_done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("config_done", 32'(bus.config_done), 32'd1);
    check("frame_count", 32'(frames_done), 32'(sent));
    check("pending_frames", 32'(exp_q.size()), 32'd0);
    idle_ok = 1'b1;
    for (int i = 0; i < idle_cyc; i++) begin
      @(posedge clk); #1;
      idle_ok &= bus.sioc && bus.siod_out && bus.siod_oe && !bus.advance && bus.config_done;
    end
    check("idle_after_done", 32'(idle_ok), 32'd1);
  endtask

  initial begin
    logic [7:0] a, v;
    for (int k = 0; k < 27; k++) oe_pat[26-k] = ((k + 1) % 9 != 0);
    drive_cmd(16'h0000);

    table_q = '{16'h1711};
    run_table(-1, -1, 20);

    table_q = '{16'h1280, 16'h1200};
    run_table(-1, -1, 20);

    table_q = '{16'h1280, 16'h1200, 16'h3A14, 16'hFFFF};
    run_table(-1, -1, 10000);

    table_q = '{16'h3A14};
    run_table(12, -1, 20);

    table_q = '{16'h1711, 16'h3A14};
    run_table(-1, 5, 20);

    for (int r = 0; r < 3; r++) begin
      table_q.delete();
      for (int j = 0; j < 4; j++) begin
        a = ($urandom_range(0, 3) == 0) ? 8'h12 : 8'($urandom_range(0, 255));
        v = 8'($urandom);
        if ({a, v} == SCCB_TERMINATOR) v = 8'h00;
        table_q.push_back({a, v});
      end
      run_table(-1, -1, 20);
    end

    exp_q.delete();
    starts = 0;
    do_reset(SCCB_TERMINATOR);
    repeat (ST) @(posedge clk);
    #1;
    check("done_before_settle", 32'(bus.config_done), 32'd0);
    @(posedge clk); #1;
    check("done_after_settle", 32'(bus.config_done), 32'd1);
    repeat (300) @(posedge clk);
    #1;
    check("no_start_when_finished", 32'(starts), 32'd0);
    check("done_advance_low", 32'(bus.advance), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
